nexys4ddr_ddr2_maint: RTL and testbench
=======================================

Name: nexys4ddr_ddr2_maint

Overview:
- Wishbone master on the DDR2 wrapper's control port (wbc_*); sequences all maintenance traffic to it.
- Waits for calibration by polling status register 0, then forwards XADC temperature samples to register 1 and issues refresh/ZQ requests to register 2.
- ZQ requests come from software pulses or a periodic timer.
- Sits beside the DDR2 wrapper in the nexys4ddr system, clocked by the wrapper's ui clock.

Parameters:
- awc, 4, control-bus address width
- dwc, 16, control-bus data width (≥12)
- POLL_CYC, 1024, idle cycles between status polls
- ZQ_PERIOD, 0, cycles between automatic ZQ requests; 0 disables the timer
- ACK_TIMEOUT, 64, maximum cycles waiting for wbm_ack_i before aborting

Ports:
- wb_clk_o  in  1  clock (ui clock driven by the DDR2 wrapper)
- async_rst_i  in  1  reset, asynchronous, active-high
- wb_rst_i  in  1  synchronous reset (wrapper's ui_clk_sync_rst)
- wbm_adr_o  out  awc  control register address
- wbm_dat_o  out  dwc  write data
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_dat_i  in  dwc  read data
- wbm_ack_i  in  1  acknowledge
- temp_i  in  12  XADC temperature code
- temp_valid_i  in  1  one-cycle strobe; temp_i valid
- ref_req_i  in  1  one-cycle strobe; request a refresh
- zq_req_i  in  1  one-cycle strobe; request ZQ calibration
- calib_done_o  out  1  last polled calibration bit
- busy_o  out  1  transaction in flight
- err_o  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset:
  - Reset is asynchronous on async_rst_i; the same reset values also load synchronously on wb_rst_i.
  - All outputs are 0; all pending flags are clear; timers are 0; last_temp = 12'h977; state = POLL.
- Pending flags:
  - ref_pend is set by ref_req_i.
  - zq_pend is set by zq_req_i or by ZQ timer expiry.
  - temp_pend is set by temp_valid_i when temp_i != last_temp; the sample is latched into temp_q.
  - A flag clears on the ack of its write.
  - If a set and a clear land in the same cycle, set wins.
- ZQ timer:
  - Counts only while calib_done_o = 1 and ZQ_PERIOD != 0.
  - On reaching ZQ_PERIOD-1 it wraps to 0 and sets zq_pend.
- States:
  - POLL: issues a read of addr 0. On ack: calib_done_o <= wbm_dat_i[0], poll timer cleared, then → IDLE.
  - IDLE: selects the next transaction by fixed priority:
    1. temp_pend: write addr 1, data = {0, temp_q}.
    2. ref_pend and calib_done_o: write addr 2, data = 1.
    3. zq_pend and calib_done_o: write addr 2, data = 2.
    4. Poll timer = POLL_CYC-1: → POLL.
    - Otherwise the poll timer increments.
    - Selecting a write → XFER.
  - XFER (and POLL's bus phase):
    - cyc, stb, adr, dat and we are registered and held stable until ack.
    - On the ack cycle cyc/stb drop on the next edge; return to IDLE with the matching flag cleared. For a temp write, last_temp <= temp_q.
- Transaction rules:
  - Exactly one transaction at a time; minimum one idle cycle between transactions.
  - busy_o = wbm_cyc_o.
  - If ref_pend and zq_pend are both set, they go out as two separate writes, never merged, because the wrapper edge-detects each bit.
- Timeout:
  - If no ack arrives within ACK_TIMEOUT cycles of the stb assertion, cyc/stb drop, err_o pulses for 1 cycle, and the state returns to IDLE.
  - The pending flag stays set, so the write is retried.
  - A poll timeout sets calib_done_o = 0.
- Calibration loss: a poll returning bit0 = 0 drops calib_done_o. ref/zq remain pending but blocked; temperature writes continue.
- Mid-transaction reset: cyc/stb deassert immediately (async).

Optional Feature:
- Macro: NEXYS4DDR_MAINT_STATS_EN.
- When defined, adds output stats_o[47:0] = {timeout_cnt[15:0], zq_cnt[15:0], ref_cnt[15:0]}.
  - Each field counts acked ref writes, acked zq writes and timeouts respectively.
  - Each field saturates at 16'hFFFF; all fields are cleared by reset.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- Calibration wait: slave returns reg0 = 0 for 3 polls, then 1 → reads every POLL_CYC+~3 cycles; calib_done_o rises after the 4th ack; no writes occur before then.
- Temperature write: temp_valid_i with temp_i = 12'hA10 → one write, addr 1, dat 16'h0A10. Then temp_valid_i with 12'hA10 again → no write.
- Simultaneous requests: ref_req_i and zq_req_i in the same cycle → write addr 2 dat 1, then write addr 2 dat 2, separated by ≥1 idle cycle.
- ZQ timer: ZQ_PERIOD = 500, calibrated, no other traffic → addr-2 dat-2 writes every 500 cycles (± transaction latency).
- Timeout and retry: slave withholds ack → err_o pulses at ACK_TIMEOUT = 64 cycles; the same write is reissued and succeeds when the slave acks.
- Reset during XFER: assert async_rst_i with stb high → cyc/stb low the same cycle; state returns to POLL; pending flags are clear.

Source files
------------

// File: rtl/nexys4ddr_ddr2_maint_if.sv
// Wishbone control-bus bundle between the maintenance master and the DDR2
// wrapper's wbc_* port. Signal names are from the master's point of view.
interface nexys4ddr_ddr2_maint_if #(
    parameter int awc = 4,
    parameter int dwc = 16
);
    logic [awc-1:0] wbm_adr_o;
    logic [dwc-1:0] wbm_dat_o;
    logic           wbm_we_o;
    logic           wbm_cyc_o;
    logic           wbm_stb_o;
    logic [dwc-1:0] wbm_dat_i;
    logic           wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/nexys4ddr_ddr2_maint.sv
// nexys4ddr_ddr2_maint: sequences all maintenance traffic on the DDR2 wrapper
// control port -- calibration polling (reg 0), temperature forwarding (reg 1)
// and refresh/ZQ requests (reg 2), one transaction at a time.
// Optional: define NEXYS4DDR_MAINT_STATS_EN to add the stats_o counters.
module nexys4ddr_ddr2_maint #(
    parameter int awc         = 4,
    parameter int dwc         = 16,
    parameter int POLL_CYC    = 1024,
    parameter int ZQ_PERIOD   = 0,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        wb_clk_o,
    input  logic        async_rst_i,
    input  logic        wb_rst_i,
    nexys4ddr_ddr2_maint_if.master wbm,
    input  logic [11:0] temp_i,
    input  logic        temp_valid_i,
    input  logic        ref_req_i,
    input  logic        zq_req_i,
    output logic        calib_done_o,
    output logic        busy_o,
    output logic        err_o
`ifdef NEXYS4DDR_MAINT_STATS_EN
    ,
    output logic [47:0] stats_o
`endif
);
    localparam int PW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int ZW = (ZQ_PERIOD > 1) ? $clog2(ZQ_PERIOD) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [11:0] TEMP_RST = 12'h977;

    typedef enum logic [1:0] {ST_POLL, ST_IDLE, ST_XFER} state_t;
    typedef enum logic [1:0] {K_POLL, K_TEMP, K_REF, K_ZQ} kind_t;

    state_t         state_q, state_d;
    kind_t          kind_q, kind_d;
    logic           cyc_q, cyc_d, we_q, we_d;
    logic [awc-1:0] adr_q, adr_d;
    logic [dwc-1:0] dat_q, dat_d;
    logic           calib_q, calib_d, err_q, err_d;
    logic           ref_pend_q, ref_pend_d, zq_pend_q, zq_pend_d, temp_pend_q, temp_pend_d;
    logic [11:0]    temp_q, temp_d, last_temp_q, last_temp_d;
    logic [PW-1:0]  poll_tmr_q, poll_tmr_d;
    logic [ZW-1:0]  zq_tmr_q, zq_tmr_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           ref_clr, zq_clr, temp_clr, zq_hit, temp_set;
    logic           unused_dat;

    // Only bit 0 of the status read is meaningful.
    assign unused_dat = ^wbm.wbm_dat_i[dwc-1:1];

    // stb is the same flop as cyc: every cycle is a single-beat access.
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign calib_done_o  = calib_q;
    assign busy_o        = cyc_q;
    assign err_o         = err_q;

    // Next-state: transaction FSM, pending flags, timers, sync reset last.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        calib_d     = calib_q;
        err_d       = 1'b0;
        last_temp_d = last_temp_q;
        poll_tmr_d  = poll_tmr_q;
        zq_tmr_d    = zq_tmr_q;
        tmo_d       = tmo_q;
        ref_clr     = 1'b0;
        zq_clr      = 1'b0;
        temp_clr    = 1'b0;
        zq_hit      = 1'b0;

        unique case (state_q)
            ST_POLL: begin
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                adr_d   = '0;
                dat_d   = '0;
                kind_d  = K_POLL;
                tmo_d   = '0;
                state_d = ST_XFER;
            end
            ST_IDLE: begin
                tmo_d = '0;
                if (temp_pend_q) begin
                    {cyc_d, we_d, kind_d, state_d} = {2'b11, K_TEMP, ST_XFER};
                    adr_d = awc'(1);
                    dat_d = dwc'(temp_q);
                end else if (ref_pend_q && calib_q) begin
                    {cyc_d, we_d, kind_d, state_d} = {2'b11, K_REF, ST_XFER};
                    adr_d = awc'(2);
                    dat_d = dwc'(1);
                end else if (zq_pend_q && calib_q) begin
                    {cyc_d, we_d, kind_d, state_d} = {2'b11, K_ZQ, ST_XFER};
                    adr_d = awc'(2);
                    dat_d = dwc'(2);
                end else if (poll_tmr_q == PW'(POLL_CYC - 1)) begin
                    state_d = ST_POLL;
                end else begin
                    poll_tmr_d = poll_tmr_q + PW'(1);
                end
            end
            ST_XFER: begin
                if (wbm.wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                    unique case (kind_q)
                        K_POLL: begin
                            calib_d    = wbm.wbm_dat_i[0];
                            poll_tmr_d = '0;
                        end
                        // Record the value actually written; temp_q may have moved on.
                        K_TEMP: begin
                            temp_clr    = 1'b1;
                            last_temp_d = dat_q[11:0];
                        end
                        K_REF: ref_clr = 1'b1;
                        K_ZQ:  zq_clr  = 1'b1;
                    endcase
                end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    // Abort; the pending flag stays set so the write is retried.
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    if (kind_q == K_POLL) begin
                        calib_d    = 1'b0;
                        poll_tmr_d = '0;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = ST_POLL;
        endcase

        if (calib_q && ZQ_PERIOD != 0) begin
            if (zq_tmr_q == ZW'(ZQ_PERIOD - 1)) begin
                zq_tmr_d = '0;
                zq_hit   = 1'b1;
            end else begin
                zq_tmr_d = zq_tmr_q + ZW'(1);
            end
        end

        // Set wins over a same-cycle clear.
        temp_set    = temp_valid_i && (temp_i != last_temp_q);
        temp_d      = temp_set ? temp_i : temp_q;
        temp_pend_d = (temp_pend_q && !temp_clr) || temp_set;
        ref_pend_d  = (ref_pend_q && !ref_clr) || ref_req_i;
        zq_pend_d   = (zq_pend_q && !zq_clr) || zq_req_i || zq_hit;

        if (wb_rst_i) begin
            state_d     = ST_POLL;
            kind_d      = K_POLL;
            {cyc_d, we_d, calib_d, err_d} = '0;
            adr_d       = '0;
            dat_d       = '0;
            {ref_pend_d, zq_pend_d, temp_pend_d} = '0;
            temp_d      = '0;
            last_temp_d = TEMP_RST;
            poll_tmr_d  = '0;
            zq_tmr_d    = '0;
            tmo_d       = '0;
        end
    end

    // State registers; async_rst_i forces cyc/stb low immediately.
    always_ff @(posedge wb_clk_o or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q     <= ST_POLL;
            kind_q      <= K_POLL;
            {cyc_q, we_q, calib_q, err_q} <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            {ref_pend_q, zq_pend_q, temp_pend_q} <= '0;
            temp_q      <= '0;
            last_temp_q <= TEMP_RST;
            poll_tmr_q  <= '0;
            zq_tmr_q    <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            {cyc_q, we_q, calib_q, err_q} <= {cyc_d, we_d, calib_d, err_d};
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            {ref_pend_q, zq_pend_q, temp_pend_q} <= {ref_pend_d, zq_pend_d, temp_pend_d};
            temp_q      <= temp_d;
            last_temp_q <= last_temp_d;
            poll_tmr_q  <= poll_tmr_d;
            zq_tmr_q    <= zq_tmr_d;
            tmo_q       <= tmo_d;
        end
    end

`ifdef NEXYS4DDR_MAINT_STATS_EN
    logic [15:0] ref_cnt_q, ref_cnt_d, zq_cnt_q, zq_cnt_d, tmo_cnt_q, tmo_cnt_d;

    assign stats_o = {tmo_cnt_q, zq_cnt_q, ref_cnt_q};

    // Saturating event counters: acked ref writes, acked zq writes, timeouts.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        zq_cnt_d  = zq_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        if (ref_clr && ref_cnt_q != 16'hFFFF) ref_cnt_d = ref_cnt_q + 16'd1;
        if (zq_clr  && zq_cnt_q  != 16'hFFFF) zq_cnt_d  = zq_cnt_q  + 16'd1;
        if (err_d   && tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (wb_rst_i) begin
            ref_cnt_d = '0;
            zq_cnt_d  = '0;
            tmo_cnt_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge wb_clk_o or posedge async_rst_i) begin
        if (async_rst_i) begin
            ref_cnt_q <= '0;
            zq_cnt_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            zq_cnt_q  <= zq_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_nexys4ddr_ddr2_maint.sv
// Directed bench for nexys4ddr_ddr2_maint: behavioural wishbone slave,
// transaction log, and one task per scenario with hand-computed expectations.
module tb_nexys4ddr_ddr2_maint;
    localparam int POLL = 32;
    localparam int ZQP  = 500;
    localparam int TMO  = 64;

    logic        clk = 1'b0, async_rst = 1'b1, wb_rst = 1'b0;
    logic [11:0] temp = '0;
    logic        temp_valid = 1'b0, ref_req = 1'b0, zq_req = 1'b0;
    logic        calib, busy, err;
`ifdef NEXYS4DDR_MAINT_STATS_EN
    logic [47:0] stats;
`endif

    int checks = 0, errors = 0;

    nexys4ddr_ddr2_maint_if #(.awc(4), .dwc(16)) bus ();

    nexys4ddr_ddr2_maint #(.awc(4), .dwc(16), .POLL_CYC(POLL), .ZQ_PERIOD(ZQP),
                           .ACK_TIMEOUT(TMO)) dut (
        .wb_clk_o     (clk),
        .async_rst_i  (async_rst),
        .wb_rst_i     (wb_rst),
        .wbm          (bus),
        .temp_i       (temp),
        .temp_valid_i (temp_valid),
        .ref_req_i    (ref_req),
        .zq_req_i     (zq_req),
        .calib_done_o (calib),
        .busy_o       (busy),
        .err_o        (err)
`ifdef NEXYS4DDR_MAINT_STATS_EN
        ,
        .stats_o      (stats)
`endif
    );

    always #5 clk = ~clk;

    // Slave: acks one cycle after stb unless told to withhold.
    int rd_cnt = 0, calib_after = 3;
    bit hold_all = 0, hold_a1 = 0;
    assign bus.wbm_dat_i = (rd_cnt >= calib_after) ? 16'd1 : 16'd0;
    always @(posedge clk or posedge async_rst)
        if (async_rst) bus.wbm_ack_i <= 1'b0;
        else bus.wbm_ack_i <= bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i && !hold_all
                              && !(hold_a1 && bus.wbm_we_o && bus.wbm_adr_o == 4'd1);

    // Monitor: log acked transactions with start/ack sample numbers.
    int ncyc = 0, nlog = 0, start_c = 0, run = 0, last_run = 0, err_run = 0, err_n = 0;
    bit cyc_prev = 0;
    int l_adr[1024], l_dat[1024], l_st[1024], l_ack[1024];
    bit l_we[1024];
    always @(posedge clk) begin
        ncyc     <= ncyc + 1;
        cyc_prev <= bus.wbm_cyc_o;
        if (bus.wbm_cyc_o && !cyc_prev) start_c <= ncyc;
        if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i && nlog < 1024) begin
            l_adr[nlog] <= int'(bus.wbm_adr_o);
            l_dat[nlog] <= int'(bus.wbm_we_o ? bus.wbm_dat_o : bus.wbm_dat_i);
            l_we[nlog]  <= bus.wbm_we_o;
            l_st[nlog]  <= start_c;
            l_ack[nlog] <= ncyc;
            nlog        <= nlog + 1;
            if (!bus.wbm_we_o) rd_cnt <= rd_cnt + 1;
        end
        if (bus.wbm_stb_o) run <= run + 1;
        else if (run != 0) begin
            last_run <= run;
            run      <= 0;
        end
        if (err) begin
            err_n   <= err_n + 1;
            err_run <= (!bus.wbm_stb_o && run != 0) ? run : last_run;
        end
    end

    // we/adr of -1 match anything; returns at a negedge, idx = -1 on budget expiry.
    task automatic find_txn(input int from, input int we, input int adr, input int budget,
                            output int idx);
        idx = -1;
        for (int c = 0; c <= budget && idx < 0; c++) begin
            for (int i = from; i < nlog && idx < 0; i++)
                if ((we < 0 || int'(l_we[i]) == we) && (adr < 0 || l_adr[i] == adr)) idx = i;
            if (idx < 0) @(negedge clk);
        end
    endtask

    function automatic int count_w(input int from, input int adr);
        int n = 0;
        for (int i = from; i < nlog; i++) if (l_we[i] && l_adr[i] == adr) n++;
        return n;
    endfunction

    task automatic pulse_temp(input logic [11:0] v);
        @(negedge clk); temp = v; temp_valid = 1'b1;
        @(negedge clk); temp_valid = 1'b0;
    endtask

    task automatic pulse_req(input bit r, input bit z);
        @(negedge clk); ref_req = r; zq_req = z;
        @(negedge clk); ref_req = 1'b0; zq_req = 1'b0;
    endtask

    task automatic test_reset;
        async_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin
            errors++; $display("FAIL reset_cyc_stb: cyc=%b stb=%b want 0 0", bus.wbm_cyc_o, bus.wbm_stb_o);
        end
        checks++;
        if ({calib, busy, err} !== 3'b000) begin
            errors++; $display("FAIL reset_status: calib/busy/err=%b want 000", {calib, busy, err});
        end
        checks++;
        if ({bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o} !== 21'd0) begin
            errors++; $display("FAIL reset_bus: we=%b adr=%h dat=%h want 0", bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o);
        end
    endtask

    task automatic test_calib_wait;
        int seen = 0;
        int nwr = 0;
        @(negedge clk); async_rst = 1'b0;
        for (int c = 0; c < 400 && seen < 4; c++) begin
            @(negedge clk);
            if (rd_cnt != seen) begin
                seen = rd_cnt;
                checks++;
                if (calib !== 1'(seen >= 4)) begin
                    errors++; $display("FAIL calib_after_poll%0d: calib=%b want %0d", seen, calib, seen >= 4);
                end
            end
        end
        checks++;
        if (seen != 4) begin
            errors++; $display("FAIL calib_poll_count: polls=%0d want 4", seen);
        end
        checks++;
        if (l_we[0] !== 1'b0 || l_adr[0] != 0) begin
            errors++; $display("FAIL calib_first_read: we=%b adr=%0d want 0 0", l_we[0], l_adr[0]);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (l_ack[i] - l_ack[i-1] != POLL + 3) begin
                errors++; $display("FAIL calib_poll_period%0d: got %0d want %0d", i, l_ack[i] - l_ack[i-1], POLL + 3);
            end
        end
        for (int i = 0; i < nlog; i++) if (l_we[i]) nwr++;
        checks++;
        if (nwr != 0 || nlog != 4) begin
            errors++; $display("FAIL calib_no_writes: writes=%0d txns=%0d want 0 4", nwr, nlog);
        end
    endtask

    task automatic test_temp_write;
        int i0, idx;
        i0 = nlog;
        pulse_temp(12'hA10);
        find_txn(i0, 1, 1, 60, idx);
        checks++;
        if (idx < 0) begin
            errors++; $display("FAIL temp_write: no addr1 write, want dat 0a10");
        end else if (l_dat[idx] != 'h0A10) begin
            errors++; $display("FAIL temp_write: dat=%h want 0a10", l_dat[idx]);
        end
        i0 = nlog;
        pulse_temp(12'hA10);
        repeat (60) @(negedge clk);
        checks++;
        if (count_w(i0, 1) != 0) begin
            errors++; $display("FAIL temp_repeat: writes=%0d want 0", count_w(i0, 1));
        end
    endtask

    task automatic test_back_to_back;
        int i0, a, b;
        i0 = nlog;
        pulse_req(1'b1, 1'b1);
        find_txn(i0, 1, 2, 60, a);
        checks++;
        if (a < 0 || l_dat[a] != 1) begin
            errors++; $display("FAIL b2b_first: idx=%0d dat=%0d want ref dat 1", a, (a < 0) ? -1 : l_dat[a]);
        end else begin
            find_txn(a + 1, 1, 2, 60, b);
            checks++;
            if (b < 0 || l_dat[b] != 2) begin
                errors++; $display("FAIL b2b_second: idx=%0d dat=%0d want zq dat 2", b, (b < 0) ? -1 : l_dat[b]);
            end else begin
                checks++;
                if (l_st[b] - l_ack[a] != 2) begin
                    errors++; $display("FAIL b2b_gap: start-ack=%0d want 2", l_st[b] - l_ack[a]);
                end
            end
        end
    endtask

    task automatic test_zq_timer;
        int a, b;
        find_txn(nlog, 1, 2, 700, a);
        checks++;
        if (a < 0 || l_dat[a] != 2) begin
            errors++; $display("FAIL zq_timer_first: idx=%0d want a dat-2 write", a);
        end else begin
            find_txn(a + 1, 1, 2, 700, b);
            checks++;
            if (b < 0 || l_dat[b] != 2) begin
                errors++; $display("FAIL zq_timer_second: idx=%0d want a dat-2 write", b);
            end else begin
                checks++;
                if (l_st[b] - l_st[a] < ZQP - 5 || l_st[b] - l_st[a] > ZQP + 5) begin
                    errors++; $display("FAIL zq_timer_period: got %0d want %0d+-5", l_st[b] - l_st[a], ZQP);
                end
            end
        end
    endtask

    task automatic test_timeout;
        int i0, e0, idx;
        bit got = 0;
        e0 = err_n;
        i0 = nlog;
        hold_a1 = 1;
        pulse_temp(12'h5C3);
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (err) got = 1;
        end
        hold_a1 = 0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL timeout_err: no err_o pulse within 200 cycles");
        end
        @(negedge clk);
        checks++;
        if (err_run != TMO) begin
            errors++; $display("FAIL timeout_len: stb cycles=%0d want %0d", err_run, TMO);
        end
        find_txn(i0, 1, 1, 40, idx);
        checks++;
        if (idx < 0 || l_dat[idx] != 'h05C3) begin
            errors++; $display("FAIL timeout_retry: idx=%0d dat=%h want 05c3", idx, (idx < 0) ? 0 : l_dat[idx]);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err_n - e0 != 1) begin
            errors++; $display("FAIL timeout_err_cycles: got %0d want 1", err_n - e0);
        end
    endtask

    task automatic test_calib_loss;
        int i0, a;
        calib_after = 1 << 30;
        find_txn(nlog, 0, 0, 60, a);
        checks++;
        if (a < 0 || calib !== 1'b0) begin
            errors++; $display("FAIL calib_loss_drop: idx=%0d calib=%b want 0", a, calib);
        end
        i0 = nlog;
        pulse_req(1'b1, 1'b0);
        pulse_temp(12'h111);
        repeat (80) @(negedge clk);
        checks++;
        if (count_w(i0, 1) != 1) begin
            errors++; $display("FAIL calib_loss_temp: writes=%0d want 1", count_w(i0, 1));
        end
        checks++;
        if (count_w(i0, 2) != 0) begin
            errors++; $display("FAIL calib_loss_blocked: addr2 writes=%0d want 0", count_w(i0, 2));
        end
        calib_after = 0;
        find_txn(nlog, 1, 2, 100, a);
        checks++;
        if (a < 0 || l_dat[a] != 1) begin
            errors++; $display("FAIL calib_loss_ref_resume: idx=%0d want ref write dat 1", a);
        end
    endtask

    task automatic test_reset_xfer;
        int i0, a;
        hold_all = 1;
        pulse_req(1'b1, 1'b1);
        pulse_temp(12'h777);
        for (int c = 0; c < 120 && !(bus.wbm_stb_o && bus.wbm_we_o); c++) @(negedge clk);
        checks++;
        if (!(bus.wbm_stb_o && bus.wbm_we_o)) begin
            errors++; $display("FAIL rst_xfer_setup: no write in flight");
        end
        #2 async_rst = 1'b1;
        #1;
        checks++;
        if ({bus.wbm_cyc_o, bus.wbm_stb_o, busy} !== 3'b000) begin
            errors++; $display("FAIL rst_xfer_drop: cyc/stb/busy=%b want 000", {bus.wbm_cyc_o, bus.wbm_stb_o, busy});
        end
        hold_all = 0;
        repeat (3) @(negedge clk);
        i0 = nlog;
        async_rst = 1'b0;
        find_txn(i0, -1, -1, 40, a);
        checks++;
        if (a < 0 || l_we[a] !== 1'b0 || l_adr[a] != 0) begin
            errors++; $display("FAIL rst_xfer_poll: idx=%0d want read of addr 0 first", a);
        end
        repeat (150) @(negedge clk);
        checks++;
        if (count_w(i0, 1) + count_w(i0, 2) != 0 || calib !== 1'b1) begin
            errors++; $display("FAIL rst_xfer_flags: writes=%0d calib=%b want 0 1", count_w(i0, 1) + count_w(i0, 2), calib);
        end
    endtask

    task automatic test_sync_reset;
        int a, i0;
        @(negedge clk); wb_rst = 1'b1;
        @(negedge clk); wb_rst = 1'b0;
        i0 = nlog;
        checks++;
        if ({calib, busy} !== 2'b00) begin
            errors++; $display("FAIL sync_rst_state: calib/busy=%b want 00", {calib, busy});
        end
        find_txn(i0, -1, -1, 10, a);
        checks++;
        if (a < 0 || l_we[a] !== 1'b0 || l_adr[a] != 0) begin
            errors++; $display("FAIL sync_rst_poll: idx=%0d want read of addr 0 first", a);
        end
    endtask

    initial begin
        test_reset();
        test_calib_wait();
        test_temp_write();
        test_back_to_back();
        test_zq_timer();
        test_timeout();
        test_calib_loss();
        test_reset_xfer();
        test_sync_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
